// File: rtl/stream_mux2.sv
// Two-input packet-aware stream multiplexer with round-robin arbitration at
// packet granularity and a single registered output stage.
module stream_mux2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_src,
  input  logic              m_ready,
  output logic [7:0]        pkt_cnt
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              m_src_q, m_src_d;
  logic [7:0]        pkt_cnt_q, pkt_cnt_d;

  logic              slot_free;
  logic              gnt0, gnt1;
  logic              in_xfer;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  assign slot_free = !m_valid_q || m_ready;

  // Grant depends only on state, priority and the two valids, never on last or data.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        gnt0 = s0_valid && (!s1_valid || !prio_q);
        gnt1 = s1_valid && (!s0_valid || prio_q);
      end
      LOCK0:   gnt0 = 1'b1;
      LOCK1:   gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign s0_ready = rst_n && gnt0 && slot_free;
  assign s1_ready = rst_n && gnt1 && slot_free;

  assign in_xfer  = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  assign sel_last = gnt1 ? s1_last : s0_last;
  assign sel_data = gnt1 ? s1_data : s0_data;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (in_xfer) begin
      case (state_q)
        IDLE: begin
          if (sel_last) prio_d = !gnt1;
          else          state_d = gnt1 ? LOCK1 : LOCK0;
        end
        LOCK0, LOCK1: begin
          if (sel_last) begin
            state_d = IDLE;
            prio_d  = !gnt1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_src_d   = m_src_q;
    pkt_cnt_d = pkt_cnt_q;
    if (in_xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      m_last_d  = sel_last;
      m_src_d   = gnt1;
    end else if (slot_free) begin
      m_valid_d = 1'b0;
    end
    if (m_valid_q && m_ready && m_last_q) pkt_cnt_d = pkt_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_src_q   <= 1'b0;
      pkt_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_src_q   <= m_src_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_src   = m_src_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_stream_mux2.sv
// Table-driven bench for stream_mux2: per-cycle vectors check readies, m_valid
// and pkt_cnt, while a queue scoreboard checks every beat leaving the mux.
module tb_stream_mux2;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              s0_valid, s0_last, s0_ready;
  logic [DATA_W-1:0] s0_data;
  logic              s1_valid, s1_last, s1_ready;
  logic [DATA_W-1:0] s1_data;
  logic              m_valid, m_last, m_src, m_ready;
  logic [DATA_W-1:0] m_data;
  logic [7:0]        pkt_cnt;

  always #5 clk = ~clk;

  stream_mux2 #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
    .m_ready(m_ready), .pkt_cnt(pkt_cnt)
  );

  typedef struct {
    logic       v0; logic [7:0] d0; logic l0;
    logic       v1; logic [7:0] d1; logic l1;
    logic       mr;
    logic       r0; logic r1; logic mv; logic [7:0] pc;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int v0, input int d0, input int l0,
                     input int v1, input int d1, input int l1, input int mr,
                     input int r0, input int r1, input int mv, input int pc);
    vec_t v;
    v.v0 = 1'(v0); v.d0 = 8'(d0); v.l0 = 1'(l0);
    v.v1 = 1'(v1); v.d1 = 8'(d1); v.l1 = 1'(l1);
    v.mr = 1'(mr);
    v.r0 = 1'(r0); v.r1 = 1'(r1); v.mv = 1'(mv); v.pc = 8'(pc);
    vecs.push_back(v);
  endtask

  task automatic run(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t       v;
      logic [9:0] e;
      v = vecs[i];
      @(negedge clk);
      s0_valid = v.v0; s0_data = v.d0; s0_last = v.l0;
      s1_valid = v.v1; s1_data = v.d1; s1_last = v.l1;
      m_ready  = v.mr;
      #1;
      check($sformatf("%s[%0d].s0_ready", tag, i), 32'(s0_ready), 32'(v.r0));
      check($sformatf("%s[%0d].s1_ready", tag, i), 32'(s1_ready), 32'(v.r1));
      check($sformatf("%s[%0d].m_valid", tag, i), 32'(m_valid), 32'(v.mv));
      check($sformatf("%s[%0d].pkt_cnt", tag, i), 32'(pkt_cnt), 32'(v.pc));
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s[%0d].beat: got %0h expected no beat", tag, i,
                   {m_src, m_last, m_data});
        end else begin
          e = sb.pop_front();
          check($sformatf("%s[%0d].beat", tag, i), 32'({m_src, m_last, m_data}), 32'(e));
        end
      end
      if (v.v0 && v.r0) sb.push_back({1'b0, v.l0, v.d0});
      if (v.v1 && v.r1) sb.push_back({1'b1, v.l1, v.d1});
    end
    vecs.delete();
  endtask

  initial begin
    int n0, n1;
    s0_valid = 1'b1; s0_data = '0; s0_last = 1'b0;
    s1_valid = 1'b1; s1_data = '0; s1_last = 1'b0;
    m_ready  = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst.m_valid", 32'(m_valid), 0);
    check("rst.m_data", 32'(m_data), 0);
    check("rst.m_last", 32'(m_last), 0);
    check("rst.m_src", 32'(m_src), 0);
    check("rst.pkt_cnt", 32'(pkt_cnt), 0);
    check("rst.s0_ready", 32'(s0_ready), 0);
    check("rst.s1_ready", 32'(s1_ready), 0);
    @(negedge clk);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst_n = 1'b1;

    // Single 4-beat packet from input 0.
    add(1, 'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(1, 'h01, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    add(1, 'h02, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    add(1, 'h03, 1, 0, 0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    run("p1");

    // Asynchronous reset mid-packet; prio is 1 here, so reset must restore prio=0.
    add(1, 'h00, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 'h01, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    run("rst_mid");
    @(posedge clk);
    #2;
    check("rst_mid.pre_m_valid", 32'(m_valid), 1);
    check("rst_mid.pre_m_data", 32'(m_data), 'h01);
    rst_n = 1'b0;
    #1;
    check("rst_mid.m_valid", 32'(m_valid), 0);
    check("rst_mid.pkt_cnt", 32'(pkt_cnt), 0);
    check("rst_mid.s0_ready", 32'(s0_ready), 0);
    sb.delete();
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Both inputs contend: s0 packet, s1 packet, s0 packet.
    add(1, 'h00, 0, 1, 'h10, 0, 1, 1, 0, 0, 0);
    add(1, 'h01, 0, 1, 'h10, 0, 1, 1, 0, 1, 0);
    add(1, 'h02, 0, 1, 'h10, 0, 1, 1, 0, 1, 0);
    add(1, 'h03, 1, 1, 'h10, 0, 1, 1, 0, 1, 0);
    add(1, 'h00, 0, 1, 'h10, 0, 1, 0, 1, 1, 0);
    add(1, 'h00, 0, 1, 'h11, 0, 1, 0, 1, 1, 1);
    add(1, 'h00, 0, 1, 'h12, 0, 1, 0, 1, 1, 1);
    add(1, 'h00, 0, 1, 'h13, 1, 1, 0, 1, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    add(1, 'h01, 0, 0, 0, 0, 1, 1, 0, 1, 2);
    add(1, 'h02, 0, 0, 0, 0, 1, 1, 0, 1, 2);
    add(1, 'h03, 1, 0, 0, 0, 1, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
    run("p2");

    // Output stalled 5 cycles with beat 01 held; s1 waits with a 1-beat packet.
    add(1, 'h00, 0, 0, 0, 0, 1, 1, 0, 0, 3);
    add(1, 'h01, 0, 0, 0, 0, 1, 1, 0, 1, 3);
    for (int k = 0; k < 5; k++) add(1, 'h02, 0, 1, 'h10, 1, 0, 0, 0, 1, 3);
    add(1, 'h02, 0, 1, 'h10, 1, 1, 1, 0, 1, 3);
    add(1, 'h03, 1, 1, 'h10, 1, 1, 1, 0, 1, 3);
    add(0, 0, 0, 1, 'h10, 1, 1, 0, 1, 1, 3);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5);
    run("p3");

    // s0 locked, then s0_valid drops for 3 cycles while s1 waits.
    add(1, 'h00, 0, 1, 'h10, 0, 1, 1, 0, 0, 5);
    add(0, 0, 0, 1, 'h10, 0, 1, 1, 0, 1, 5);
    add(0, 0, 0, 1, 'h10, 0, 1, 1, 0, 0, 5);
    add(0, 0, 0, 1, 'h10, 0, 1, 1, 0, 0, 5);
    add(1, 'h01, 0, 1, 'h10, 0, 1, 1, 0, 0, 5);
    add(1, 'h02, 0, 1, 'h10, 0, 1, 1, 0, 1, 5);
    add(1, 'h03, 1, 1, 'h10, 0, 1, 1, 0, 1, 5);
    add(0, 0, 0, 1, 'h10, 0, 1, 0, 1, 1, 5);
    add(0, 0, 0, 1, 'h11, 1, 1, 0, 1, 1, 6);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 6);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7);
    run("p4");

    // Continuous single-beat packets on both inputs: strict alternation, pkt_cnt wraps.
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 262; i++) begin
      add(1, n0 & 'hff, 1, 1, 'h80 | (n1 & 'h7f), 1, 1,
          (i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 0 : 1,
          (i > 0) ? 1 : 0, (7 + ((i > 0) ? i - 1 : 0)) & 'hff);
      if (i % 2 == 0) n0++;
      else            n1++;
    end
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, (7 + 261) & 'hff);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, (7 + 262) & 'hff);
    run("p5");

    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
